// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: decodes the IR and sequences FETCH/DECODE/EXE/MEM/WB,
// driving datapath selects and strobes, and counting retired instructions.
module mc_ctrl #(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instr,
    input  logic             zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic [1:0]       EXTOp,
    output logic [2:0]       ALUOp,
    output logic [2:0]       DMEXTOp,
    output logic             if_beq,
    output logic             if_jal,
    output logic             if_jr,
    output logic             if_sll,
    output logic             if_slt,
    output logic             if_sra,
    output logic             sw,
    output logic             sh,
    output logic             sb,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t           state_r;
    state_t           next_s;
    logic [RET_W-1:0] retired_r;
    logic             pc_write_s, ir_write_s, reg_write_s, mem_write_s, done_s;

    logic [5:0] op_s, funct_s;
    logic is_rtype_s, is_addu_s, is_subu_s, is_slt_s, is_sll_s, is_sra_s, is_jr_s, is_ralu_s;
    logic is_ori_s, is_lui_s, is_beq_s, is_jal_s;
    logic is_lw_s, is_lh_s, is_lhu_s, is_lb_s, is_lbu_s, is_load_s;
    logic is_sw_s, is_sh_s, is_sb_s, is_store_s, is_nop_s;
    logic       exe_alusrc_s;
    logic [1:0] exe_extop_s;
    logic [2:0] exe_aluop_s, ld_ext_s;

    // Register-field bits and the zero flag are consumed by the datapath, not by control.
    logic unused_fields_s;
    assign unused_fields_s = ^{Instr[25:6], zero};

    assign op_s       = Instr[31:26];
    assign funct_s    = Instr[5:0];
    assign is_rtype_s = (op_s == 6'h00);
    assign is_addu_s  = is_rtype_s && (funct_s == 6'h21);
    assign is_subu_s  = is_rtype_s && (funct_s == 6'h23);
    assign is_slt_s   = is_rtype_s && (funct_s == 6'h2A);
    assign is_sll_s   = is_rtype_s && (funct_s == 6'h00);
    assign is_sra_s   = is_rtype_s && (funct_s == 6'h03);
    assign is_jr_s    = is_rtype_s && (funct_s == 6'h08);
    assign is_ralu_s  = is_addu_s | is_subu_s | is_slt_s | is_sll_s | is_sra_s;
    assign is_ori_s   = (op_s == 6'h0D);
    assign is_lui_s   = (op_s == 6'h0F);
    assign is_beq_s   = (op_s == 6'h04);
    assign is_jal_s   = (op_s == 6'h03);
    assign is_lw_s    = (op_s == 6'h23);
    assign is_lh_s    = (op_s == 6'h21);
    assign is_lhu_s   = (op_s == 6'h25);
    assign is_lb_s    = (op_s == 6'h20);
    assign is_lbu_s   = (op_s == 6'h24);
    assign is_load_s  = is_lw_s | is_lh_s | is_lhu_s | is_lb_s | is_lbu_s;
    assign is_sw_s    = (op_s == 6'h2B);
    assign is_sh_s    = (op_s == 6'h29);
    assign is_sb_s    = (op_s == 6'h28);
    assign is_store_s = is_sw_s | is_sh_s | is_sb_s;
    assign is_nop_s   = ~(is_ralu_s | is_jr_s | is_ori_s | is_lui_s | is_beq_s |
                          is_jal_s | is_load_s | is_store_s);

    // ALU-side selects established in EXE and held through MEM/WB so address/result stay stable.
    assign exe_alusrc_s = is_ori_s | is_lui_s | is_load_s | is_store_s;
    assign exe_extop_s  = is_lui_s ? 2'd2 :
                          (is_load_s | is_store_s | is_beq_s) ? 2'd1 : 2'd0;
    assign exe_aluop_s  = is_ori_s ? 3'd2 :
                          (is_subu_s | is_slt_s | is_beq_s) ? 3'd1 : 3'd0;
    assign ld_ext_s     = is_lbu_s ? 3'd1 : is_lb_s ? 3'd2 :
                          is_lhu_s ? 3'd3 : is_lh_s ? 3'd4 : 3'd0;

    // Next-state and per-state output decode.
    always_comb begin
        next_s      = S_FETCH;
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        done_s      = 1'b0;
        RegDst      = 1'b0;
        ALUSrc      = 1'b0;
        MemToReg    = 1'b0;
        EXTOp       = 2'd0;
        ALUOp       = 3'd0;
        DMEXTOp     = 3'd0;
        if_beq      = 1'b0;
        if_jal      = 1'b0;
        if_jr       = 1'b0;
        if_sll      = 1'b0;
        if_slt      = 1'b0;
        if_sra      = 1'b0;
        sw          = 1'b0;
        sh          = 1'b0;
        sb          = 1'b0;
        case (state_r)
            S_FETCH: begin
                ir_write_s = 1'b1;
                next_s     = S_DECODE;
            end
            S_DECODE: begin
                if (is_jal_s) begin
                    next_s = S_WB;
                end else if (is_nop_s) begin
                    pc_write_s = 1'b1;
                    done_s     = 1'b1;
                    next_s     = S_FETCH;
                end else begin
                    next_s = S_EXE;
                end
            end
            S_EXE: begin
                ALUSrc = exe_alusrc_s;
                EXTOp  = exe_extop_s;
                ALUOp  = exe_aluop_s;
                if_sll = is_sll_s;
                if_slt = is_slt_s;
                if_sra = is_sra_s;
                if (is_beq_s) begin
                    if_beq     = 1'b1;
                    pc_write_s = 1'b1;
                    done_s     = 1'b1;
                    next_s     = S_FETCH;
                end else if (is_jr_s) begin
                    if_jr      = 1'b1;
                    pc_write_s = 1'b1;
                    done_s     = 1'b1;
                    next_s     = S_FETCH;
                end else if (is_load_s | is_store_s) begin
                    next_s = S_MEM;
                end else begin
                    next_s = S_WB;
                end
            end
            S_MEM: begin
                ALUSrc  = exe_alusrc_s;
                EXTOp   = exe_extop_s;
                ALUOp   = exe_aluop_s;
                DMEXTOp = ld_ext_s;
                if (is_store_s) begin
                    mem_write_s = 1'b1;
                    sw          = is_sw_s;
                    sh          = is_sh_s;
                    sb          = is_sb_s;
                    pc_write_s  = 1'b1;
                    done_s      = 1'b1;
                    next_s      = S_FETCH;
                end else begin
                    next_s = S_WB;
                end
            end
            S_WB: begin
                ALUSrc      = exe_alusrc_s;
                EXTOp       = exe_extop_s;
                ALUOp       = exe_aluop_s;
                RegDst      = is_ralu_s;
                if_sll      = is_sll_s;
                if_slt      = is_slt_s;
                if_sra      = is_sra_s;
                MemToReg    = is_load_s;
                DMEXTOp     = ld_ext_s;
                if_jal      = is_jal_s;
                reg_write_s = 1'b1;
                pc_write_s  = 1'b1;
                done_s      = 1'b1;
                next_s      = S_FETCH;
            end
            default: begin
                next_s = S_FETCH;
            end
        endcase
    end

    // Reset suppresses every strobe in the cycle it is asserted, aborting any partial instruction.
    assign PCWrite    = pc_write_s  & ~reset;
    assign IRWrite    = ir_write_s  & ~reset;
    assign RegWrite   = reg_write_s & ~reset;
    assign MemWrite   = mem_write_s & ~reset;
    assign instr_done = done_s      & ~reset;
    assign state      = state_r;
    assign retired    = retired_r;

    // State register and retired-instruction counter (wraps silently).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_FETCH;
            retired_r <= {RET_W{1'b0}};
        end else begin
            state_r <= next_s;
            if (instr_done) begin
                retired_r <= retired_r + {{(RET_W-1){1'b0}}, 1'b1};
            end else begin
                retired_r <= retired_r;
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a spec-level model queues the expected per-cycle outputs,
// and a negedge monitor compares them against the DUT (plus a narrow-counter wrap instance).
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        zero;
    logic [31:0] Instr;
    always #5 clk = ~clk;

    logic PCWrite, IRWrite, RegWrite, MemWrite, RegDst, ALUSrc, MemToReg;
    logic [1:0] EXTOp;
    logic [2:0] ALUOp, DMEXTOp, state;
    logic if_beq, if_jal, if_jr, if_sll, if_slt, if_sra, sw, sh, sb, instr_done;
    logic [31:0] retired;

    logic n_pcw, n_irw, n_rw, n_mw, n_rd, n_as, n_m2r;
    logic [1:0] n_ext;
    logic [2:0] n_alu, n_dme, n_st;
    logic n_beq, n_jal, n_jr, n_sll, n_slt, n_sra, n_sw, n_sh, n_sb, n_done;
    logic [3:0] n_retired;

    mc_ctrl #(.RET_W(32)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .zero(zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .EXTOp(EXTOp),
        .ALUOp(ALUOp), .DMEXTOp(DMEXTOp), .if_beq(if_beq), .if_jal(if_jal),
        .if_jr(if_jr), .if_sll(if_sll), .if_slt(if_slt), .if_sra(if_sra),
        .sw(sw), .sh(sh), .sb(sb), .state(state), .instr_done(instr_done),
        .retired(retired)
    );

    mc_ctrl #(.RET_W(4)) dut_narrow (
        .clk(clk), .reset(reset), .Instr(Instr), .zero(zero),
        .PCWrite(n_pcw), .IRWrite(n_irw), .RegWrite(n_rw), .MemWrite(n_mw),
        .RegDst(n_rd), .ALUSrc(n_as), .MemToReg(n_m2r), .EXTOp(n_ext),
        .ALUOp(n_alu), .DMEXTOp(n_dme), .if_beq(n_beq), .if_jal(n_jal),
        .if_jr(n_jr), .if_sll(n_sll), .if_slt(n_slt), .if_sra(n_sra),
        .sw(n_sw), .sh(n_sh), .sb(n_sb), .state(n_st), .instr_done(n_done),
        .retired(n_retired)
    );

    typedef struct packed {
        logic [2:0] st;
        logic pcw, irw, rw, mw, regdst, alusrc, memtoreg;
        logic [1:0] extop;
        logic [2:0] aluop, dmextop;
        logic beq, jal, jr, sll, slt, sra, sw, sh, sb, done;
    } outv_t;

    typedef struct {
        outv_t       v;
        outv_t       m;
        logic [31:0] ret;
        bit          chk_ret;
        logic [31:0] instr;
        int          ph;
    } exp_t;

    typedef enum int {K_NOP, K_ADDU, K_SUBU, K_SLT, K_SLL, K_SRA, K_JR, K_ORI, K_LUI,
                      K_LW, K_LH, K_LHU, K_LB, K_LBU, K_SW, K_SH, K_SB, K_BEQ, K_JAL} kind_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] count = 32'd0;
    outv_t       act;

    assign act = {state, PCWrite, IRWrite, RegWrite, MemWrite, RegDst, ALUSrc, MemToReg,
                  EXTOp, ALUOp, DMEXTOp, if_beq, if_jal, if_jr, if_sll, if_slt, if_sra,
                  sw, sh, sb, instr_done};

    function automatic kind_t classify(input logic [31:0] ins);
        kind_t k;
        k = K_NOP;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h21: k = K_ADDU;
                    6'h23: k = K_SUBU;
                    6'h2A: k = K_SLT;
                    6'h00: k = K_SLL;
                    6'h03: k = K_SRA;
                    6'h08: k = K_JR;
                    default: k = K_NOP;
                endcase
            end
            6'h0D: k = K_ORI;
            6'h0F: k = K_LUI;
            6'h23: k = K_LW;
            6'h21: k = K_LH;
            6'h25: k = K_LHU;
            6'h20: k = K_LB;
            6'h24: k = K_LBU;
            6'h2B: k = K_SW;
            6'h29: k = K_SH;
            6'h28: k = K_SB;
            6'h04: k = K_BEQ;
            6'h03: k = K_JAL;
            default: k = K_NOP;
        endcase
        return k;
    endfunction

    // State walk per instruction class, packed as five 3-bit states (step 0 in the low bits).
    function automatic void path_of(input kind_t k, output int n, output logic [14:0] seq);
        if (k == K_NOP) begin
            n = 2; seq = {3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
        end else if (k inside {K_BEQ, K_JR}) begin
            n = 3; seq = {3'd0, 3'd0, 3'd2, 3'd1, 3'd0};
        end else if (k == K_JAL) begin
            n = 3; seq = {3'd0, 3'd0, 3'd4, 3'd1, 3'd0};
        end else if (k inside {K_SW, K_SH, K_SB}) begin
            n = 4; seq = {3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
        end else if (k inside {K_LW, K_LH, K_LHU, K_LB, K_LBU}) begin
            n = 5; seq = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        end else begin
            n = 4; seq = {3'd0, 3'd4, 3'd2, 3'd1, 3'd0};
        end
    endfunction

    function automatic void exp_of(input kind_t k, input logic [2:0] st,
                                   output outv_t v, output outv_t m);
        bit is_r, is_ld, is_st;
        is_r  = k inside {K_ADDU, K_SUBU, K_SLT, K_SLL, K_SRA};
        is_ld = k inside {K_LW, K_LH, K_LHU, K_LB, K_LBU};
        is_st = k inside {K_SW, K_SH, K_SB};
        v = '0; m = '1; v.st = st;
        if (st >= 3'd2) begin
            if (k == K_ORI) begin v.alusrc = 1'b1; v.aluop = 3'd2; end
            if (k == K_LUI) begin v.alusrc = 1'b1; v.extop = 2'd2; end
            if (is_ld || is_st) begin v.alusrc = 1'b1; v.extop = 2'd1; end
            if (k == K_BEQ) begin v.extop = 2'd1; v.aluop = 3'd1; end
            if (k inside {K_SUBU, K_SLT}) v.aluop = 3'd1;
            if (k inside {K_SLL, K_SRA}) m.aluop = 3'd0;
        end
        case (st)
            3'd0: v.irw = 1'b1;
            3'd1: if (k == K_NOP) begin v.pcw = 1'b1; v.done = 1'b1; end
            3'd2: begin
                if (k == K_BEQ) begin v.beq = 1'b1; v.pcw = 1'b1; v.done = 1'b1; end
                if (k == K_JR)  begin v.jr  = 1'b1; v.pcw = 1'b1; v.done = 1'b1; end
                if (is_r) begin m.sll = 1'b0; m.slt = 1'b0; m.sra = 1'b0; end
            end
            3'd3: begin
                m.dmextop = 3'd0;
                if (is_st) begin
                    v.mw = 1'b1; v.pcw = 1'b1; v.done = 1'b1;
                    v.sw = (k == K_SW); v.sh = (k == K_SH); v.sb = (k == K_SB);
                end
            end
            3'd4: begin
                v.rw = 1'b1; v.pcw = 1'b1; v.done = 1'b1;
                v.regdst = is_r;
                v.sll = (k == K_SLL); v.slt = (k == K_SLT); v.sra = (k == K_SRA);
                v.memtoreg = is_ld;
                v.jal = (k == K_JAL);
                case (k)
                    K_LBU:   v.dmextop = 3'd1;
                    K_LB:    v.dmextop = 3'd2;
                    K_LHU:   v.dmextop = 3'd3;
                    K_LH:    v.dmextop = 3'd4;
                    default: v.dmextop = 3'd0;
                endcase
            end
            default: ;
        endcase
    endfunction

    // Reset cycle: only state (optional) and the strobes are defined.
    function automatic exp_t reset_entry(input logic [2:0] st, input bit chk_st);
        exp_t e;
        e.v = '0; e.m = '0; e.v.st = st;
        e.m.st = chk_st ? 3'b111 : 3'b000;
        e.m.pcw = 1'b1; e.m.irw = 1'b1; e.m.rw = 1'b1; e.m.mw = 1'b1; e.m.done = 1'b1;
        e.ret = 32'd0; e.chk_ret = 1'b0; e.instr = Instr; e.ph = -1;
        return e;
    endfunction

    // zsel < 0 randomizes zero each cycle; abort_at selects the step during which reset is raised.
    task automatic run(input logic [31:0] ins, input int zsel, input int abort_at);
        kind_t       k;
        int          n;
        logic [14:0] seq;
        exp_t        e;
        k = classify(ins);
        path_of(k, n, seq);
        Instr = ins;
        for (int i = 0; i < n; i++) begin
            zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            if (i == abort_at) begin
                reset = 1'b1;
                q.push_back(reset_entry(seq[3*i +: 3], 1'b1));
                @(posedge clk); #1;
                reset = 1'b0;
                count = 32'd0;
                return;
            end
            exp_of(k, seq[3*i +: 3], e.v, e.m);
            e.ret = count; e.chk_ret = 1'b1; e.instr = ins; e.ph = i;
            q.push_back(e);
            if (e.v.done) count = count + 32'd1;
            @(posedge clk); #1;
        end
    endtask

    // Monitor: one expected entry per cycle, compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (((act ^ e.v) & e.m) !== '0) begin
                failures++;
                $display("FAIL outputs instr=%h step=%0d actual=%h expected=%h mask=%h",
                         e.instr, e.ph, act, e.v, e.m);
            end
            if (e.chk_ret) begin
                checks++;
                if (retired !== e.ret) begin
                    failures++;
                    $display("FAIL retired instr=%h step=%0d actual=%0d expected=%0d",
                             e.instr, e.ph, retired, e.ret);
                end
                checks++;
                if (n_retired !== e.ret[3:0]) begin
                    failures++;
                    $display("FAIL retired_wrap instr=%h step=%0d actual=%0d expected=%0d",
                             e.instr, e.ph, n_retired, e.ret[3:0]);
                end
            end
        end
    end

    logic [31:0] dir_tbl [18] = '{
        32'h00221821, 32'h00221823, 32'h0022182A, 32'h00021880, 32'h00021883, 32'h03E00008,
        32'h34220005, 32'h3C011234, 32'h8C410003, 32'h84410003, 32'h94410003, 32'h80410003,
        32'h90410003, 32'hAC410003, 32'hA4410003, 32'hA0410003, 32'h10220004, 32'h0C000C00
    };

    initial begin
        logic [31:0] base, rnd, ins;
        int          ab;
        reset = 1'b1; zero = 1'b0; Instr = 32'd0;
        @(posedge clk); #1;
        q.push_back(reset_entry(3'd0, 1'b0));
        @(posedge clk); #1;
        q.push_back(reset_entry(3'd0, 1'b1));
        @(posedge clk); #1;
        reset = 1'b0;
        count = 32'd0;

        run(32'h00221821, -1, -1);   // addu
        run(32'h80410003, -1, -1);   // lb
        run(32'hA0410003, -1, -1);   // sb
        run(32'h10220004, 0, -1);    // beq, not taken
        run(32'h10220004, 1, -1);    // beq, taken
        run(32'h0C000C00, -1, -1);   // jal
        run(32'hFC000000, -1, -1);   // unknown opcode
        run(32'hAC410003, -1, 3);    // sw aborted by reset in MEM
        run(32'h00221821, -1, -1);   // counter restarts from 0
        foreach (dir_tbl[i]) run(dir_tbl[i], -1, -1);

        for (int t = 0; t < 400; t++) begin
            rnd = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                base = dir_tbl[$urandom_range(0, 17)];
                ins = (base[31:26] == 6'h00) ? {6'h00, rnd[25:6], base[5:0]}
                                             : {base[31:26], rnd[25:0]};
            end else begin
                ins = rnd;
            end
            ab = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1;
            run(ins, -1, ab);
        end

        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
